bowl_sequencer: RTL

//  Innings controller for the AI bowler: sequences each delivery (enable AI, capture dy/dx,

---
 rtl/cricket_pkg.sv | 20 ++
 rtl/delay_counter.sv | 35 +++
 rtl/bowl_sequencer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/cricket_pkg.sv
// Shared types and widths for the cricket bowling datapath.
package cricket_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARM,
      ST_LATCH,
      ST_FLIGHT,
      ST_SCORE,
      ST_GAP,
      ST_DONE
   } bowl_state_t;

   localparam int SPEED_W  = 4;
   localparam int RUNS_W   = 3;
   localparam int SCORE_W  = 8;
   localparam int COUNT_W  = 4;
   localparam int MAX_RUNS = 6;

endpackage

// File: rtl/delay_counter.sv
// Loadable down-counter with a zero flag; holds at zero until reloaded.
module delay_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             enable,
   output logic             zero
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (enable && (count_q != '0)) begin
         count_d = count_q - WIDTH'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/bowl_sequencer.sv
// Innings controller for the AI bowler: arms the bowler, launches each ball and keeps the score.
// Optional BOWL_TIMEOUT_EN scores a dot ball when a delivery stays in flight too long.
module bowl_sequencer
   import cricket_pkg::*;
#(
   parameter int BALLS_PER_OVER = 6,
   parameter int OVERS          = 2,
   parameter int MAX_WICKETS    = 10,
   parameter int GAP_CYCLES     = 50000000,
   parameter int FLIGHT_TIMEOUT = 200000000
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic [SPEED_W-1:0] ai_dy,
   input  logic [SPEED_W-1:0] ai_dx,
   input  logic               ai_throw,
   input  logic               ball_done,
   input  logic               wicket,
   input  logic [RUNS_W-1:0]  runs,
   output logic               ai_en,
   output logic               launch,
   output logic [SPEED_W-1:0] ball_dy,
   output logic [SPEED_W-1:0] ball_dx,
   output logic [2:0]         ball_count,
   output logic [COUNT_W-1:0] over_count,
   output logic [COUNT_W-1:0] wickets,
   output logic [SCORE_W-1:0] total_runs,
   output logic               busy,
   output logic               game_over
);

   // One counter serves both the inter-ball gap and the flight timeout, so size it for the larger.
   localparam int DLY_MAX = (GAP_CYCLES > FLIGHT_TIMEOUT) ? GAP_CYCLES : FLIGHT_TIMEOUT;
   localparam int DLY_W   = $clog2(DLY_MAX + 1);

   localparam logic [DLY_W-1:0]   GAP_LOAD  = DLY_W'(GAP_CYCLES - 1);
   localparam logic [2:0]         LAST_BALL = 3'(BALLS_PER_OVER - 1);
   localparam logic [COUNT_W-1:0] OVERS_C   = COUNT_W'(OVERS);
   localparam logic [COUNT_W-1:0] WKT_C     = COUNT_W'(MAX_WICKETS);
`ifdef BOWL_TIMEOUT_EN
   localparam logic [DLY_W-1:0]   FLIGHT_LOAD = DLY_W'(FLIGHT_TIMEOUT - 1);
`endif

   function automatic logic [SCORE_W-1:0] add_runs_sat(input logic [SCORE_W-1:0] total,
                                                       input logic [RUNS_W-1:0]  r);
      logic [RUNS_W-1:0] r_lim;
      logic [SCORE_W:0]  sum;
      r_lim = (r > RUNS_W'(MAX_RUNS)) ? RUNS_W'(MAX_RUNS) : r;
      sum   = {1'b0, total} + (SCORE_W + 1)'(r_lim);
      add_runs_sat = sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
   endfunction

   bowl_state_t        state_q, state_d;
   logic [SPEED_W-1:0] ball_dy_q, ball_dy_d;
   logic [SPEED_W-1:0] ball_dx_q, ball_dx_d;
   logic [2:0]         ball_count_q, ball_count_d;
   logic [COUNT_W-1:0] over_count_q, over_count_d;
   logic [COUNT_W-1:0] wickets_q, wickets_d;
   logic [SCORE_W-1:0] total_runs_q, total_runs_d;
   logic               launch_q, launch_d;
   logic               hit_wicket_q, hit_wicket_d;
   logic [RUNS_W-1:0]  hit_runs_q, hit_runs_d;

   logic               dly_load;
   logic [DLY_W-1:0]   dly_load_val;
   logic               dly_en;
   logic               dly_zero;
   logic               over_wrap;

   delay_counter #(
      .WIDTH (DLY_W)
   ) u_delay (
      .clock    (clock),
      .reset    (reset),
      .load     (dly_load),
      .load_val (dly_load_val),
      .enable   (dly_en),
      .zero     (dly_zero)
   );

   always_comb begin
      state_d      = state_q;
      ball_dy_d    = ball_dy_q;
      ball_dx_d    = ball_dx_q;
      ball_count_d = ball_count_q;
      over_count_d = over_count_q;
      wickets_d    = wickets_q;
      total_runs_d = total_runs_q;
      launch_d     = 1'b0;
      hit_wicket_d = hit_wicket_q;
      hit_runs_d   = hit_runs_q;
      dly_load     = 1'b0;
      dly_load_val = GAP_LOAD;
      dly_en       = 1'b0;
      over_wrap    = (ball_count_q == LAST_BALL);

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               ball_dy_d    = '0;
               ball_dx_d    = '0;
               ball_count_d = '0;
               over_count_d = '0;
               wickets_d    = '0;
               total_runs_d = '0;
               state_d      = ST_ARM;
            end
         end
         ST_ARM: begin
            state_d = ST_LATCH;
         end
         ST_LATCH: begin
            // No throw from the bowler means the innings cannot continue.
            if (ai_throw) begin
               ball_dy_d = ai_dy;
               ball_dx_d = ai_dx;
               launch_d  = 1'b1;
`ifdef BOWL_TIMEOUT_EN
               dly_load     = 1'b1;
               dly_load_val = FLIGHT_LOAD;
`endif
               state_d   = ST_FLIGHT;
            end else begin
               state_d = ST_DONE;
            end
         end
         ST_FLIGHT: begin
`ifdef BOWL_TIMEOUT_EN
            dly_en = 1'b1;
`endif
            if (ball_done) begin
               hit_wicket_d = wicket;
               hit_runs_d   = runs;
               state_d      = ST_SCORE;
`ifdef BOWL_TIMEOUT_EN
            end else if (dly_zero) begin
               hit_wicket_d = 1'b0;
               hit_runs_d   = '0;
               state_d      = ST_SCORE;
`endif
            end
         end
         ST_SCORE: begin
            if (hit_wicket_q) begin
               wickets_d = wickets_q + COUNT_W'(1);
            end else begin
               total_runs_d = add_runs_sat(total_runs_q, hit_runs_q);
            end
            ball_count_d = over_wrap ? 3'd0 : ball_count_q + 3'd1;
            over_count_d = over_wrap ? over_count_q + COUNT_W'(1) : over_count_q;
            dly_load     = 1'b1;
            dly_load_val = GAP_LOAD;
            // End-of-innings test looks at the counts this ball produces.
            if ((wickets_d == WKT_C) || (over_count_d == OVERS_C)) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_GAP;
            end
         end
         ST_GAP: begin
            dly_en = 1'b1;
            if (dly_zero) begin
               state_d = ST_ARM;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         ball_dy_q    <= '0;
         ball_dx_q    <= '0;
         ball_count_q <= '0;
         over_count_q <= '0;
         wickets_q    <= '0;
         total_runs_q <= '0;
         launch_q     <= 1'b0;
         hit_wicket_q <= 1'b0;
         hit_runs_q   <= '0;
      end else begin
         state_q      <= state_d;
         ball_dy_q    <= ball_dy_d;
         ball_dx_q    <= ball_dx_d;
         ball_count_q <= ball_count_d;
         over_count_q <= over_count_d;
         wickets_q    <= wickets_d;
         total_runs_q <= total_runs_d;
         launch_q     <= launch_d;
         hit_wicket_q <= hit_wicket_d;
         hit_runs_q   <= hit_runs_d;
      end
   end

   assign ai_en      = (state_q == ST_ARM) || (state_q == ST_LATCH);
   assign launch     = launch_q;
   assign ball_dy    = ball_dy_q;
   assign ball_dx    = ball_dx_q;
   assign ball_count = ball_count_q;
   assign over_count = over_count_q;
   assign wickets    = wickets_q;
   assign total_runs = total_runs_q;
   assign busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
   assign game_over  = (state_q == ST_DONE);

endmodule
